cdc_req_ctrl: RTL



---
 rtl/cdc_req_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cdc_req_ctrl.sv
// cdc_req_ctrl: source-side four-phase req/ack handshake controller for a clock-domain crossing.
// Define CDC_REQ_CTRL_TIMEOUT_EN to add a per-phase timeout with a FLUSH recovery state.
module cdc_req_ctrl #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ack_sync,
    output logic              req,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              start_drop,
    output logic              timeout
);
    if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cdc_req_ctrl: TIMEOUT_CYCLES must be within 4..65535");
    end

`ifdef CDC_REQ_CTRL_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO, FLUSH} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt, cnt_nx;
    logic          to_nx;
`else
    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;
`endif

    state_t            state, state_nx;
    logic              req_nx, busy_nx, done_nx, drop_nx;
    logic [DATA_W-1:0] data_nx;

    // A start is only accepted in IDLE with the previous ack fully returned low.
    always_comb begin
        state_nx = state;
        req_nx   = req;
        busy_nx  = busy;
        data_nx  = data_out;
        done_nx  = 1'b0;
        drop_nx  = start && (state != IDLE || ack_sync);
`ifdef CDC_REQ_CTRL_TIMEOUT_EN
        to_nx    = 1'b0;
`endif
        case (state)
            IDLE:
                if (start && !ack_sync) begin
                    state_nx = REQ_HI;
                    req_nx   = 1'b1;
                    busy_nx  = 1'b1;
                    data_nx  = data_in;
                end
            REQ_HI:
                if (ack_sync) begin
                    state_nx = REQ_LO;
                    req_nx   = 1'b0;
                end
`ifdef CDC_REQ_CTRL_TIMEOUT_EN
                else if (cnt == LIMIT) begin
                    state_nx = FLUSH;
                    req_nx   = 1'b0;
                    to_nx    = 1'b1;
                end
`endif
            REQ_LO:
                if (!ack_sync) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
`ifdef CDC_REQ_CTRL_TIMEOUT_EN
                else if (cnt == LIMIT) begin
                    state_nx = FLUSH;
                    to_nx    = 1'b1;
                end
            FLUSH:
                if (!ack_sync) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= IDLE;
            req        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_drop <= 1'b0;
            data_out   <= '0;
        end else begin
            state      <= state_nx;
            req        <= req_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            start_drop <= drop_nx;
            data_out   <= data_nx;
        end
    end

`ifdef CDC_REQ_CTRL_TIMEOUT_EN
    // Phase age: restarts on every state change, counts only while waiting on ack.
    assign cnt_nx = (state_nx == state && (state == REQ_HI || state == REQ_LO)) ? cnt + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            timeout <= to_nx;
        end
    end
`else
    assign timeout = 1'b0;
`endif
endmodule
